// File: rtl/clk_div_pkg.sv
// Shared constants and clamp helpers for the multi-channel clock divider.
// Duty helper is only used when CLK_DIV_DUTY_EN is defined.
package clk_div_pkg;

  localparam int CNT_W_DEF       = 24;
  localparam int DEFAULT_DIV_DEF = 500000;

  typedef logic [63:0] wide_t;

  // A divisor below 2 cannot form a high and a low phase.
  function automatic wide_t clamp_div(input wide_t v);
    return (v < 64'd2) ? 64'd2 : v;
  endfunction

  function automatic wide_t clamp_duty(
    input wide_t u,
    input wide_t d
  );
    if (u < 64'd1) return 64'd1;
    if (u > d - 64'd1) return d - 64'd1;
    return u;
  endfunction

endpackage

// File: rtl/clk_divider_multi_if.sv
// Control/status bundle for clk_divider_multi.
// duty_value exists only when CLK_DIV_DUTY_EN is defined.
interface clk_divider_multi_if
  import clk_div_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int CNT_W  = CNT_W_DEF
);

  logic [NUM_CH-1:0]       en;
  logic [NUM_CH-1:0]       load;
  logic [NUM_CH*CNT_W-1:0] div_value;
`ifdef CLK_DIV_DUTY_EN
  logic [NUM_CH*CNT_W-1:0] duty_value;
`endif
  logic [NUM_CH-1:0]       clk_out;
  logic [NUM_CH-1:0]       tick;
  logic [NUM_CH-1:0]       pending;

  modport master (
`ifdef CLK_DIV_DUTY_EN
    output duty_value,
`endif
    output en, load, div_value,
    input  clk_out, tick, pending
  );

  modport slave (
`ifdef CLK_DIV_DUTY_EN
    input  duty_value,
`endif
    input  en, load, div_value,
    output clk_out, tick, pending
  );

endinterface

// File: rtl/clk_div_channel.sv
// One divider channel: counter, active/pending divisor, output flops.
// CLK_DIV_DUTY_EN adds a programmable high-phase length.
module clk_div_channel
  import clk_div_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int DEFAULT_DIV = DEFAULT_DIV_DEF
) (
  input  logic             clk_MHz,
  input  logic             reset,
  input  logic             en,
  input  logic             load,
  input  logic [CNT_W-1:0] div_in,
`ifdef CLK_DIV_DUTY_EN
  input  logic [CNT_W-1:0] duty_in,
`endif
  output logic             clk_out,
  output logic             tick,
  output logic             pending
);

  localparam logic [CNT_W-1:0] DEF_D =
    CNT_W'(clamp_div(64'(DEFAULT_DIV)));
  localparam logic [CNT_W-1:0] DEF_H = DEF_D >> 1;

  logic [CNT_W-1:0] cnt, d, p, h;
  logic [CNT_W-1:0] ld_d, new_d, new_h, nxt;
  logic             upd, last;

  assign ld_d  = CNT_W'(clamp_div(64'(div_in)));
  assign new_d = load ? ld_d : p;
  assign upd   = pending | load;
  assign last  = (cnt == d - 1'b1);
  assign nxt   = last ? '0 : cnt + 1'b1;

`ifdef CLK_DIV_DUTY_EN
  logic [CNT_W-1:0] pu, new_u;
  assign new_u = load ? duty_in : pu;
  assign new_h =
    CNT_W'(clamp_duty(64'(new_u), 64'(new_d)));
`else
  assign new_h = new_d >> 1;
`endif

  always_ff @(posedge clk_MHz or posedge reset) begin
    if (reset) begin
      cnt     <= DEF_D - 1'b1;
      d       <= DEF_D;
      p       <= DEF_D;
      h       <= DEF_H;
      pending <= 1'b0;
      clk_out <= 1'b0;
      tick    <= 1'b0;
`ifdef CLK_DIV_DUTY_EN
      pu      <= DEF_H;
`endif
    end else if (!en) begin
      // Parked one cycle before a boundary so enable starts a full period.
      clk_out <= 1'b0;
      tick    <= 1'b0;
      pending <= 1'b0;
      if (upd) begin
        d   <= new_d;
        p   <= new_d;
        h   <= new_h;
        cnt <= new_d - 1'b1;
`ifdef CLK_DIV_DUTY_EN
        pu  <= new_u;
`endif
      end else begin
        cnt <= d - 1'b1;
      end
    end else if (last && upd) begin
      d       <= new_d;
      p       <= new_d;
      h       <= new_h;
      cnt     <= '0;
      pending <= 1'b0;
      clk_out <= 1'b1;
      tick    <= 1'b1;
`ifdef CLK_DIV_DUTY_EN
      pu      <= new_u;
`endif
    end else begin
      cnt     <= nxt;
      clk_out <= (nxt < h);
      tick    <= (nxt == '0);
      if (load) begin
        p       <= ld_d;
        pending <= 1'b1;
`ifdef CLK_DIV_DUTY_EN
        pu      <= duty_in;
`endif
      end
    end
  end

endmodule

// File: rtl/clk_divider_multi.sv
// N-channel programmable clock divider with boundary-aligned reloads.
// Define CLK_DIV_DUTY_EN to add per-channel duty programming.
module clk_divider_multi
  import clk_div_pkg::*;
#(
  parameter int NUM_CH      = 2,
  parameter int CNT_W       = CNT_W_DEF,
  parameter int DEFAULT_DIV = DEFAULT_DIV_DEF
) (
  input logic                clk_MHz,
  input logic                reset,
  clk_divider_multi_if.slave bus
);

  logic [NUM_CH-1:0] co, tk, pd;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    clk_div_channel #(
      .CNT_W      (CNT_W),
      .DEFAULT_DIV(DEFAULT_DIV)
    ) u_ch (
      .clk_MHz(clk_MHz),
      .reset  (reset),
      .en     (bus.en[i]),
      .load   (bus.load[i]),
      .div_in (bus.div_value[i*CNT_W +: CNT_W]),
`ifdef CLK_DIV_DUTY_EN
      .duty_in(bus.duty_value[i*CNT_W +: CNT_W]),
`endif
      .clk_out(co[i]),
      .tick   (tk[i]),
      .pending(pd[i])
    );
  end

  assign bus.clk_out = co;
  assign bus.tick    = tk;
  assign bus.pending = pd;

endmodule

// File: tb/tb_clk_divider_multi.sv
// Scoreboard bench for clk_divider_multi (2 channels, DEFAULT_DIV=4).
// Expected per-cycle outputs are queued from period/phase arithmetic.
module tb_clk_divider_multi;
  import clk_div_pkg::*;

  localparam int NCH  = 2;
  localparam int W    = 24;
  localparam int DDIV = 4;

  logic clk_MHz = 1'b0;
  logic reset   = 1'b1;
  always #5 clk_MHz = ~clk_MHz;

  clk_divider_multi_if #(.NUM_CH(NCH), .CNT_W(W)) bus ();

  clk_divider_multi #(
    .NUM_CH     (NCH),
    .CNT_W      (W),
    .DEFAULT_DIV(DDIV)
  ) dut (
    .clk_MHz(clk_MHz),
    .reset  (reset),
    .bus    (bus)
  );

  typedef struct packed {
    logic c;
    logic t;
    logic p;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int checks   = 0;
  int failures = 0;

  task automatic push_e(input int ch, input exp_t e);
    if (ch == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask

  // Positions k0..k0+n-1 of a period d with h high cycles.
  task automatic push_seq(input int ch, input int d, input int h,
                          input int k0, input int n, input logic p);
    exp_t e;
    for (int j = 0; j < n; j++) begin
      int k;
      k   = (k0 + j) % d;
      e.c = (k < h);
      e.t = (k == 0);
      e.p = p;
      push_e(ch, e);
    end
  endtask

  task automatic push_off(input int ch, input int n);
    exp_t e;
    e = '0;
    for (int j = 0; j < n; j++) push_e(ch, e);
  endtask

  task automatic set_load(input int ch, input int v);
    bus.load[ch] = 1'b1;
    bus.div_value[ch*W +: W] = W'(v);
`ifdef CLK_DIV_DUTY_EN
    bus.duty_value[ch*W +: W] = W'(v >> 1);
`endif
  endtask

  task automatic run_check(input string tag, input int maxc);
    int   c;
    exp_t e;
    logic have;
    c = 0;
    while ((q0.size() > 0 || q1.size() > 0) && c < maxc) begin
      @(posedge clk_MHz);
      #1;
      bus.load = '0;
      for (int ch = 0; ch < NCH; ch++) begin
        have = 1'b0;
        e    = '0;
        if (ch == 0 && q0.size() > 0) begin
          e = q0.pop_front(); have = 1'b1;
        end
        if (ch == 1 && q1.size() > 0) begin
          e = q1.pop_front(); have = 1'b1;
        end
        if (have) begin
          checks++;
          if (bus.clk_out[ch] !== e.c) begin
            failures++;
            $display("FAIL %s cyc%0d ch%0d clk_out got %b want %b",
                     tag, c, ch, bus.clk_out[ch], e.c);
          end
          checks++;
          if (bus.tick[ch] !== e.t) begin
            failures++;
            $display("FAIL %s cyc%0d ch%0d tick got %b want %b",
                     tag, c, ch, bus.tick[ch], e.t);
          end
          checks++;
          if (bus.pending[ch] !== e.p) begin
            failures++;
            $display("FAIL %s cyc%0d ch%0d pending got %b want %b",
                     tag, c, ch, bus.pending[ch], e.p);
          end
        end
      end
      c++;
    end
    checks++;
    if (q0.size() != 0 || q1.size() != 0) begin
      failures++;
      $display("FAIL %s budget got %0d left want 0",
               tag, q0.size() + q1.size());
      q0.delete();
      q1.delete();
    end
  endtask

  task automatic do_reset(input logic [NCH-1:0] en_v);
    @(negedge clk_MHz);
    reset     = 1'b1;
    bus.en    = en_v;
    bus.load  = '0;
    @(negedge clk_MHz);
    @(negedge clk_MHz);
    checks++;
    if ({bus.clk_out, bus.tick, bus.pending} !== '0) begin
      failures++;
      $display("FAIL reset_outs got %b want 0",
               {bus.clk_out, bus.tick, bus.pending});
    end
    reset = 1'b0;
  endtask

  task automatic test_reset;
    do_reset(2'b00);
    push_off(0, 3);
    push_off(1, 3);
    run_check("disabled_after_reset", 10);
    bus.en = 2'b11;
    push_seq(0, 4, 2, 0, 12, 1'b0);
    push_seq(1, 4, 2, 0, 12, 1'b0);
    run_check("default_div4", 20);
  endtask

  task automatic test_load5;
    do_reset(2'b11);
    set_load(0, 5);
    push_seq(0, 5, 2, 0, 20, 1'b0);
    push_seq(1, 4, 2, 0, 20, 1'b0);
    run_check("load5_ch0", 30);
  endtask

  task automatic test_pending;
    do_reset(2'b11);
    push_seq(0, 4, 2, 0, 2, 1'b0);
    push_seq(1, 4, 2, 0, 2, 1'b0);
    run_check("pend_pre", 5);
    set_load(1, 6);
    push_seq(1, 4, 2, 2, 2, 1'b1);
    push_seq(1, 6, 3, 0, 12, 1'b0);
    push_seq(0, 4, 2, 2, 14, 1'b0);
    run_check("pend_mid", 20);
    set_load(0, 6);
    push_seq(0, 6, 3, 0, 12, 1'b0);
    push_seq(1, 6, 3, 0, 12, 1'b0);
    run_check("load_on_boundary", 20);
  endtask

  task automatic test_clamp;
    do_reset(2'b11);
    set_load(0, 0);
    set_load(1, 1);
    push_seq(0, 2, 1, 0, 8, 1'b0);
    push_seq(1, 2, 1, 0, 8, 1'b0);
    run_check("clamp_0_1", 12);
  endtask

  task automatic test_back_to_back;
    do_reset(2'b11);
    push_seq(0, 4, 2, 0, 1, 1'b0);
    push_seq(1, 4, 2, 0, 1, 1'b0);
    run_check("b2b_a", 3);
    set_load(0, 7);
    push_seq(0, 4, 2, 1, 1, 1'b1);
    push_seq(1, 4, 2, 1, 1, 1'b0);
    run_check("b2b_b", 3);
    set_load(0, 3);
    push_seq(0, 4, 2, 2, 2, 1'b1);
    push_seq(0, 3, 1, 0, 9, 1'b0);
    push_seq(1, 4, 2, 2, 11, 1'b0);
    run_check("b2b_last_wins", 15);
  endtask

  task automatic test_enable;
    do_reset(2'b11);
    push_seq(0, 4, 2, 0, 1, 1'b0);
    push_seq(1, 4, 2, 0, 1, 1'b0);
    run_check("en_a", 3);
    set_load(0, 6);
    push_seq(0, 4, 2, 1, 1, 1'b1);
    push_seq(1, 4, 2, 1, 1, 1'b0);
    run_check("en_b", 3);
    bus.en = 2'b10;
    push_off(0, 4);
    push_seq(1, 4, 2, 2, 4, 1'b0);
    run_check("en_off", 8);
    bus.en = 2'b11;
    push_seq(0, 6, 3, 0, 12, 1'b0);
    push_seq(1, 4, 2, 2, 12, 1'b0);
    run_check("en_restart", 16);
  endtask

  task automatic test_async_reset;
    @(posedge clk_MHz);
    #1;
    checks++;
    if (bus.clk_out[0] !== 1'b1) begin
      failures++;
      $display("FAIL pre_async_high got %b want 1", bus.clk_out[0]);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({bus.clk_out, bus.tick} !== '0) begin
      failures++;
      $display("FAIL async_reset got %b want 0",
               {bus.clk_out, bus.tick});
    end
    @(negedge clk_MHz);
    reset = 1'b0;
  endtask

  task automatic test_long;
    do_reset(2'b11);
    set_load(0, 1001);
    push_seq(0, 1001, 500, 0, 2002, 1'b0);
    push_seq(1, 4, 2, 0, 2002, 1'b0);
    run_check("long_1001", 2100);
  endtask

  initial begin
    bus.en        = '0;
    bus.load      = '0;
    bus.div_value = '0;
`ifdef CLK_DIV_DUTY_EN
    bus.duty_value = '0;
`endif
    test_reset();
    test_load5();
    test_pending();
    test_clamp();
    test_back_to_back();
    test_enable();
    test_async_reset();
    test_long();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
